// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sonar_pkg
// Description : Shared types and default timing constants for the sonar
//               scan controller and its echo capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package sonar_pkg;

    // Default timing and geometry constants for a full-size build
    localparam int c_default_period_cycles  = 16777216;
    localparam int c_default_burst_cycles   = 524288;
    localparam int c_default_blank_cycles   = 65536;
    localparam int c_default_sample_div     = 100;
    localparam int c_default_data_width     = 16;
    localparam int c_default_echo_threshold = 0;
    localparam int c_default_angle_width    = 8;
    localparam int c_default_angle_min      = -30;
    localparam int c_default_angle_max      = 30;
    localparam int c_default_angle_step     = 10;
    localparam int c_default_count_width    = $clog2(c_default_period_cycles);

    // Ping sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BURST  = 3'd1,
        S_BLANK  = 3'd2,
        S_LISTEN = 3'd3,
        S_REPORT = 3'd4
    } scan_state_t;

    typedef logic signed [c_default_angle_width-1:0] angle_t;

    // One result record per angle
    typedef struct packed {
        angle_t                           angle;
        logic                             hit;
        logic [c_default_count_width-1:0] range;
        logic [c_default_data_width-1:0]  peak;
    } scan_result_t;

endpackage : sonar_pkg
`default_nettype wire

// File: rtl/echo_capture.sv
`default_nettype none
// ============================================================================
// Module      : echo_capture
// Description : First-threshold-crossing and peak detector for one receive
//               channel. Reusable for per-channel debug taps.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_capture #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_enable,
    input  logic [DATA_WIDTH-1:0]  i_sample,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_threshold,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic                   o_hit,
    output logic [COUNT_WIDTH-1:0] o_range,
    output logic [DATA_WIDTH-1:0]  o_peak
);

    logic                   r_hit;
    logic [COUNT_WIDTH-1:0] r_range;
    logic [DATA_WIDTH-1:0]  r_peak;

    // Latch the first strict crossing only; track the unsigned maximum
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_hit   <= 1'b0;
            r_range <= '0;
            r_peak  <= '0;
        end else if (i_enable && i_valid) begin
            if (!r_hit && (i_sample > i_threshold)) begin
                r_hit   <= 1'b1;
                r_range <= i_count;
            end
            if (i_sample > r_peak) begin
                r_peak <= i_sample;
            end
        end
    end

    assign o_hit   = r_hit;
    assign o_range = r_range;
    assign o_peak  = r_peak;

endmodule : echo_capture
`default_nettype wire

// File: rtl/sonar_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : sonar_scan_controller
// Description : Sequences repeated sonar pings (burst, blanking, listen,
//               report) while stepping the beam angle across a sweep.
//               Optional macro SCAN_BIDIR_EN selects a ping-pong sweep
//               instead of the default sawtooth wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_scan_controller
    import sonar_pkg::*;
#(
    parameter int PERIOD_CYCLES  = c_default_period_cycles,
    parameter int BURST_CYCLES   = c_default_burst_cycles,
    parameter int BLANK_CYCLES   = c_default_blank_cycles,
    parameter int SAMPLE_DIV     = c_default_sample_div,
    parameter int DATA_WIDTH     = c_default_data_width,
    parameter int ECHO_THRESHOLD = c_default_echo_threshold,
    parameter int ANGLE_WIDTH    = c_default_angle_width,
    parameter int ANGLE_MIN      = c_default_angle_min,
    parameter int ANGLE_MAX      = c_default_angle_max,
    parameter int ANGLE_STEP     = c_default_angle_step
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              enable_in,
    input  logic [DATA_WIDTH-1:0]             sample_in,
    input  logic                              sample_valid_in,
    output logic signed [ANGLE_WIDTH-1:0]     beam_angle_out,
    output logic                              burst_active_out,
    output logic                              burst_start_out,
    output logic                              adc_trigger_out,
    output logic [$clog2(PERIOD_CYCLES)-1:0]  time_since_burst_out,
    output logic                              result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0]     result_angle_out,
    output logic                              result_hit_out,
    output logic [$clog2(PERIOD_CYCLES)-1:0]  result_range_out,
    output logic [DATA_WIDTH-1:0]             result_peak_out,
    output logic                              scan_done_out,
    output logic                              busy_out
);

    localparam int c_cw = $clog2(PERIOD_CYCLES);
    localparam int c_dw = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [c_cw-1:0] c_burst_last  = c_cw'(BURST_CYCLES - 1);
    localparam logic [c_cw-1:0] c_blank_last  = c_cw'(BURST_CYCLES + BLANK_CYCLES - 1);
    localparam logic [c_cw-1:0] c_period_last = c_cw'(PERIOD_CYCLES - 1);
    localparam logic [c_dw-1:0] c_div_last    = c_dw'(SAMPLE_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] c_threshold = DATA_WIDTH'(ECHO_THRESHOLD);

    // Angle arithmetic is one bit wider so step overshoot cannot wrap
    localparam logic signed [ANGLE_WIDTH:0]   c_min_x      = (ANGLE_WIDTH+1)'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH:0]   c_max_x      = (ANGLE_WIDTH+1)'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH:0]   c_step_x     = (ANGLE_WIDTH+1)'(ANGLE_STEP);
    localparam logic signed [ANGLE_WIDTH-1:0] c_angle_min  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] c_angle_max  = ANGLE_WIDTH'(ANGLE_MAX);

    scan_state_t                    r_state;
    scan_state_t                    w_state_next;
    logic [c_cw-1:0]                r_count;
    logic [c_dw-1:0]                r_div_cnt;
    logic signed [ANGLE_WIDTH-1:0]  r_angle;
    logic                           w_enter_burst;
    logic                           w_report;

    logic                           w_cap_hit;
    logic [c_cw-1:0]                w_cap_range;
    logic [DATA_WIDTH-1:0]          w_cap_peak;

    logic signed [ANGLE_WIDTH-1:0]  r_res_angle;
    logic                           r_res_hit;
    logic [c_cw-1:0]                r_res_range;
    logic [DATA_WIDTH-1:0]          r_res_peak;

    logic signed [ANGLE_WIDTH:0]    w_angle_x;
    logic signed [ANGLE_WIDTH:0]    w_up_x;
    logic signed [ANGLE_WIDTH:0]    w_next_x;

    assign w_report      = (r_state == S_REPORT);
    assign w_enter_burst = (w_state_next == S_BURST) && (r_state != S_BURST);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; once started a ping always runs to REPORT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable_in) begin
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (r_count == c_burst_last) begin
                    w_state_next = (BLANK_CYCLES == 0) ? S_LISTEN : S_BLANK;
                end
            end
            S_BLANK: begin
                if (r_count == c_blank_last) begin
                    w_state_next = S_LISTEN;
                end
            end
            S_LISTEN: begin
                if (r_count == c_period_last) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                w_state_next = enable_in ? S_BURST : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State-decoded strobes
    always_comb begin
        burst_active_out = 1'b0;
        burst_start_out  = 1'b0;
        adc_trigger_out  = 1'b0;
        result_valid_out = 1'b0;
        busy_out         = (r_state != S_IDLE);
        case (r_state)
            S_BURST: begin
                burst_active_out = 1'b1;
                burst_start_out  = (r_count == '0);
            end
            S_BLANK, S_LISTEN: begin
                adc_trigger_out = (r_div_cnt == '0);
            end
            S_REPORT: begin
                result_valid_out = 1'b1;
            end
            default: begin
                busy_out = 1'b0;
            end
        endcase
    end

    // Ping time counter: zero at burst start, parked at zero while idle
    always_ff @(posedge clk_in) begin
        if (rst_in || w_enter_burst || (w_state_next == S_IDLE)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cw'(1);
        end
    end

    // ADC trigger divider, phase-aligned to the first post-burst cycle
    always_ff @(posedge clk_in) begin
        if (rst_in || !((r_state == S_BLANK) || (r_state == S_LISTEN))) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_div_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_dw'(1);
        end
    end

    echo_capture #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (c_cw)
    ) u_echo_capture (
        .clk         (clk_in),
        .rst         (rst_in),
        .i_clear     (w_enter_burst),
        .i_enable    (r_state == S_LISTEN),
        .i_sample    (sample_in),
        .i_valid     (sample_valid_in),
        .i_threshold (c_threshold),
        .i_count     (r_count),
        .o_hit       (w_cap_hit),
        .o_range     (w_cap_range),
        .o_peak      (w_cap_peak)
    );

    assign w_angle_x = {r_angle[ANGLE_WIDTH-1], r_angle};
    assign w_up_x    = w_angle_x + c_step_x;

`ifdef SCAN_BIDIR_EN
    logic                        r_dir_up;
    logic                        w_dir_next;
    logic signed [ANGLE_WIDTH:0] w_dn_x;

    assign w_dn_x = w_angle_x - c_step_x;

    // Ping-pong: reverse at either endpoint, clamp inside the sweep
    always_comb begin
        w_next_x   = w_angle_x;
        w_dir_next = r_dir_up;
        if (r_dir_up) begin
            if (w_angle_x >= c_max_x) begin
                w_dir_next = 1'b0;
                w_next_x   = (w_dn_x < c_min_x) ? c_min_x : w_dn_x;
            end else begin
                w_next_x   = (w_up_x > c_max_x) ? c_max_x : w_up_x;
            end
        end else begin
            if (w_angle_x <= c_min_x) begin
                w_dir_next = 1'b1;
                w_next_x   = (w_up_x > c_max_x) ? c_max_x : w_up_x;
            end else begin
                w_next_x   = (w_dn_x < c_min_x) ? c_min_x : w_dn_x;
            end
        end
    end

    // Sweep direction register, starts moving up
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dir_up <= 1'b1;
        end else if (w_report) begin
            r_dir_up <= w_dir_next;
        end
    end

    assign scan_done_out = w_report && ((r_angle == c_angle_max) || (r_angle == c_angle_min));
`else
    // Sawtooth: step up, wrap to the start once past the end
    always_comb begin
        w_next_x = (w_up_x > c_max_x) ? c_min_x : w_up_x;
    end

    assign scan_done_out = w_report && (r_angle == c_angle_max);
`endif

    // Beam angle advances only at the end of REPORT, so it is fixed per ping
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_angle <= c_angle_min;
        end else if (w_report) begin
            r_angle <= w_next_x[ANGLE_WIDTH-1:0];
        end
    end

    // Hold the last report so result_* stay stable between reports
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_res_angle <= '0;
            r_res_hit   <= 1'b0;
            r_res_range <= '0;
            r_res_peak  <= '0;
        end else if (w_report) begin
            r_res_angle <= r_angle;
            r_res_hit   <= w_cap_hit;
            r_res_range <= w_cap_range;
            r_res_peak  <= w_cap_peak;
        end
    end

    assign beam_angle_out       = r_angle;
    assign time_since_burst_out = r_count;
    assign result_angle_out     = w_report ? r_angle     : r_res_angle;
    assign result_hit_out       = w_report ? w_cap_hit   : r_res_hit;
    assign result_range_out     = w_report ? w_cap_range : r_res_range;
    assign result_peak_out      = w_report ? w_cap_peak  : r_res_peak;

endmodule : sonar_scan_controller
`default_nettype wire

// File: tb/tb_sonar_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sonar_scan_controller
// Description : Self-checking bench for sonar_scan_controller with a small
//               ping-level reference model. Honours SCAN_BIDIR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sonar_scan_controller;

    localparam int c_p     = 64;
    localparam int c_b     = 8;
    localparam int c_bl    = 4;
    localparam int c_div   = 4;
    localparam int c_th    = 100;
    localparam int c_dw    = 16;
    localparam int c_aw    = 8;
    localparam int c_amin  = -30;
    localparam int c_amax  = 30;
    localparam int c_astep = 10;
    localparam int c_cw    = 6;
`ifdef SCAN_BIDIR_EN
    localparam bit c_bidir = 1'b1;
`else
    localparam bit c_bidir = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en  = 1'b0;
    logic [c_dw-1:0]         smp = '0;
    logic                    sv  = 1'b0;
    logic signed [c_aw-1:0]  beam_angle;
    logic                    ba, bs, trig, rv, rh, sd, busy;
    logic [c_cw-1:0]         tsb, rrange;
    logic signed [c_aw-1:0]  rangle;
    logic [c_dw-1:0]         rpeak;

    sonar_scan_controller #(
        .PERIOD_CYCLES (c_p),   .BURST_CYCLES (c_b),  .BLANK_CYCLES (c_bl),
        .SAMPLE_DIV    (c_div), .DATA_WIDTH   (c_dw), .ECHO_THRESHOLD (c_th),
        .ANGLE_WIDTH   (c_aw),  .ANGLE_MIN    (c_amin), .ANGLE_MAX    (c_amax),
        .ANGLE_STEP    (c_astep)
    ) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .enable_in            (en),
        .sample_in            (smp),
        .sample_valid_in      (sv),
        .beam_angle_out       (beam_angle),
        .burst_active_out     (ba),
        .burst_start_out      (bs),
        .adc_trigger_out      (trig),
        .time_since_burst_out (tsb),
        .result_valid_out     (rv),
        .result_angle_out     (rangle),
        .result_hit_out       (rh),
        .result_range_out     (rrange),
        .result_peak_out      (rpeak),
        .scan_done_out        (sd),
        .busy_out             (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (ping-level) ----------------
    int seq[$];            // angle visited by each successive ping
    int m_idx    = 0;
    bit m_active = 1'b0;
    int m_t      = 0;      // clocks since burst start
    int q_t[$];            // listen-window valid samples: time and value
    int q_v[$];
    bit h_hit    = 1'b0;
    int h_range  = 0;
    int h_peak   = 0;
    int h_angle  = 0;
    bit chk_on   = 1'b0;

    initial begin
        int n;
        for (int a = c_amin; a <= c_amax; a += c_astep) seq.push_back(a);
        n = seq.size();
        if (c_bidir) begin
            for (int i = n - 2; i >= 1; i--) seq.push_back(seq[i]);
        end
    end

    function automatic void calc(output bit h, output int r, output int pk);
        h = 1'b0; r = 0; pk = 0;
        foreach (q_t[i]) begin
            if (!h && q_v[i] > c_th) begin
                h = 1'b1;
                r = q_t[i];
            end
            if (q_v[i] > pk) pk = q_v[i];
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_t = 0; m_idx = 0;
            h_hit = 1'b0; h_range = 0; h_peak = 0; h_angle = 0;
            q_t.delete(); q_v.delete();
        end else if (!m_active) begin
            if (en) begin
                m_active = 1'b1; m_t = 0;
                q_t.delete(); q_v.delete();
            end
        end else if (m_t == c_p) begin
            calc(h_hit, h_range, h_peak);
            h_angle = seq[m_idx];
            m_idx   = (m_idx + 1) % seq.size();
            m_t     = 0;
            q_t.delete(); q_v.delete();
            if (!en) m_active = 1'b0;
        end else begin
            if (m_t >= c_b + c_bl && sv) begin
                q_t.push_back(m_t);
                q_v.push_back(int'(smp));
            end
            m_t++;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : cmp
        bit rep, eh;
        int er, ep, ea;
        if (chk_on) begin
            rep = m_active && (m_t == c_p);
            if (rep) begin
                calc(eh, er, ep);
                ea = seq[m_idx];
            end else begin
                eh = h_hit; er = h_range; ep = h_peak; ea = h_angle;
            end
            chk("busy", busy, m_active);
            chk("burst_active", ba, m_active && (m_t < c_b));
            chk("burst_start", bs, m_active && (m_t == 0));
            chk("adc_trigger", trig, m_active && (m_t >= c_b) && (m_t < c_p) && ((m_t - c_b) % c_div == 0));
            chk("beam_angle", beam_angle, seq[m_idx]);
            chk("result_valid", rv, rep);
            chk("result_angle", rangle, ea);
            chk("result_hit", rh, eh);
            chk("result_range", rrange, er);
            chk("result_peak", rpeak, ep);
            chk("scan_done", sd, rep && ((ea == c_amax) || (c_bidir && ea == c_amin)));
            if (m_active) chk("time_since_burst", tsb, m_t % (1 << c_cw));
        end
    end

    // Running tallies of strobes, used for literal pins
    int n_trig  = 0;
    int n_burst = 0;
    always @(negedge clk) begin
        if (trig === 1'b1) n_trig++;
        if (ba === 1'b1) n_burst++;
    end

    // ---------------- stimulus ----------------
    int mode = 1;

    task automatic drive_samples();
        sv  = 1'b1;
        smp = 16'd50;
        case (mode)
            0: begin
                sv  = ($urandom_range(0, 3) != 0);
                smp = c_dw'($urandom_range(0, 400));
            end
            2: begin
                if (m_t == 15)      smp = 16'd100;
                else if (m_t == 20) smp = 16'd101;
                else if (m_t == 40) smp = 16'd300;
            end
            3: begin
                if (m_t == 10) smp = 16'd500;
                else if (m_t == 30) begin
                    sv  = 1'b0;
                    smp = 16'd900;
                end
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        drive_samples();
    endtask

    task automatic wait_result(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            #1;
            if (rv === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: result_valid_out not seen, required within 400 cycles", tag);
        end
    endtask

    initial begin
        bit ok;
        int pulses, base_trig, base_burst;
        int exp8[8];
        exp8 = '{-30, -20, -10, 0, 10, 20, 30, -30};
        exp8[7] = c_bidir ? 20 : -30;

        rst = 1'b1; en = 1'b0; mode = 1;
        step();
        chk_on = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset angle", beam_angle, -30);
        chk("reset result_peak", rpeak, 0);

        // Ping 1: flat 50 samples, single-cycle enable
        base_trig = n_trig; base_burst = n_burst;
        en = 1'b1; step(); en = 1'b0;
        wait_result("ping1", ok);
        if (ok) begin
            chk("p1 hit", rh, 0);
            chk("p1 range", rrange, 0);
            chk("p1 peak", rpeak, 50);
            chk("p1 angle", rangle, -30);
            chk("p1 triggers", n_trig - base_trig, 14);
            chk("p1 burst cycles", n_burst - base_burst, 8);
        end
        step(); #1;
        chk("p1 idle after", busy, 0);

        // Ping 2: strict threshold, first crossing at 20
        mode = 2;
        en = 1'b1; step(); en = 1'b0;
        wait_result("ping2", ok);
        if (ok) begin
            chk("p2 hit", rh, 1);
            chk("p2 range", rrange, 20);
            chk("p2 peak", rpeak, 300);
            chk("p2 angle", rangle, -20);
        end

        // Ping 3: blanking sample and invalid sample are ignored
        mode = 3;
        en = 1'b1; step(); en = 1'b0;
        wait_result("ping3", ok);
        if (ok) begin
            chk("p3 hit", rh, 0);
            chk("p3 peak", rpeak, 50);
            chk("p3 angle", rangle, -10);
        end

        // Reset in the middle of LISTEN aborts the ping
        mode = 1;
        en = 1'b1; step(); en = 1'b0;
        repeat (30) step();
        #1;
        chk("rst point count", tsb, 30);
        rst = 1'b1; step(); rst = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort angle", beam_angle, -30);
        chk("abort result_valid", rv, 0);
        chk("abort result_hit", rh, 0);
        chk("abort result_peak", rpeak, 0);
        chk("abort count", tsb, 0);
        pulses = 0;
        repeat (80) begin step(); #1; if (rv === 1'b1) pulses++; end
        chk("abort no report", pulses, 0);

        // Continuous sweep over 8 pings
        mode = 0;
        en = 1'b1;
        for (int p = 0; p < 8; p++) begin
            wait_result("sweep", ok);
            if (ok) begin
                chk("sweep angle", rangle, exp8[p]);
                chk("sweep scan_done", sd, (exp8[p] == c_amax) || (c_bidir && exp8[p] == c_amin));
            end
            if (p == 7) en = 1'b0;
        end
        step(); #1;
        chk("sweep idle", busy, 0);

        // Enable dropped at count 3: ping completes, exactly one report
        en = 1'b1; step();
        repeat (3) step();
        en = 1'b0;
        wait_result("drop", ok);
        pulses = 0;
        repeat (80) begin step(); #1; if (rv === 1'b1) pulses++; end
        chk("drop extra reports", pulses, 0);
        chk("drop idle", busy, 0);

        // Random enable, samples and occasional reset
        mode = 0;
        repeat (1500) begin
            step();
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0; en = 1'b0;
        repeat (100) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sonar_scan_controller
`default_nettype wire
